// File: rtl/uart_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_pkg
// Description : Shared receiver FSM encoding and parity-mode constants.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_CLEANUP = 3'd5
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_2ff.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_sync_2ff
// Description : 1-bit two-flop synchroniser, resets to the idle-high level.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_sync_2ff (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_Async;
            r_sync <= r_meta;
        end
    end

    assign o_Sync = r_sync;

endmodule : uart_sync_2ff
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : uart_rx_cfg
// Description : Configurable UART receiver (data bits, parity, stop bits);
//               optional frame-match pulse enabled by macro UART_RX_MATCH_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MATCH_VALUE  = 8'h41
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Rx_Match
);

    localparam int                c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [3:0]        c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        c_STOP_LAST = 4'(STOP_BITS - 1);

    logic                 w_rx;
    logic                 w_bit_done;

    rx_state_t            r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_frm_acc;
    logic                 r_dv;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_par_err;
    logic                 r_frame_err;

    uart_sync_2ff u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_Rx_Serial),
        .o_Sync  (w_rx)
    );

    assign w_bit_done = (r_cnt == c_CNT_LAST);

    // Data shifts in from the top so the first (LSB) bit lands at index 0.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_frm_acc   <= 1'b0;
            r_dv        <= 1'b0;
            r_byte      <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (!w_rx) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx) begin
                            r_par_acc <= 1'b0;
                            r_frm_acc <= 1'b0;
                            r_state   <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (!w_bit_done) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        if (r_idx == c_DATA_LAST) begin
                            r_idx   <= '0;
                            r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!w_bit_done) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt     <= '0;
                        r_par_acc <= (PARITY == PAR_ODD) ? ~(^r_shift ^ w_rx)
                                                         :  (^r_shift ^ w_rx);
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (!w_bit_done) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (r_idx == c_STOP_LAST) begin
                            r_idx       <= '0;
                            r_dv        <= 1'b1;
                            r_byte      <= r_shift;
                            r_par_err   <= r_par_acc;
                            r_frame_err <= r_frm_acc | ~w_rx;
                            r_state     <= ST_CLEANUP;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_frm_acc <= r_frm_acc | ~w_rx;
                        end
                    end
                end
                ST_CLEANUP: begin
                    // Hold here through a break so it yields a single frame.
                    if (w_rx) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Rx_DV      = r_dv;
    assign o_Rx_Byte    = r_byte;
    assign o_Parity_Err = (PARITY == PAR_NONE) ? 1'b0 : r_par_err;
    assign o_Frame_Err  = r_frame_err;

`ifdef UART_RX_MATCH_EN
    localparam logic [DATA_BITS-1:0] c_MATCH = DATA_BITS'(MATCH_VALUE);

    logic r_match;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_match <= 1'b0;
        end else begin
            r_match <= r_dv && (r_byte == c_MATCH) && !o_Parity_Err && !r_frame_err;
        end
    end

    assign o_Rx_Match = r_match;
`else
    logic w_match_unused;
    assign w_match_unused = ^MATCH_VALUE;
    assign o_Rx_Match     = 1'b0;
`endif

endmodule : uart_rx_cfg
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_uart_rx_cfg
// Description : Directed self-checking bench for uart_rx_cfg in four configurations.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_uart_rx_cfg;

`ifdef UART_RX_MATCH_EN
    localparam int c_MEN = 1;
`else
    localparam int c_MEN = 0;
`endif

    logic clk;
    logic rst;
    logic rx0, rx1, rx2, rx3;
    logic dv0, dv1, dv2, dv3;
    logic [7:0] byte0, byte2, byte3;
    logic [6:0] byte1;
    logic perr0, perr1, perr2, perr3;
    logic ferr0, ferr1, ferr2, ferr3;
    logic m0, m1, m2, m3;

    int checks   = 0;
    int failures = 0;
    int dv_cnt [4];
    int m_cnt  [4];
    int m_ok   [4];
    logic [3:0] prev_dv;
    logic [7:0] fast_byte [4];
    int fast_err = 0;

    uart_rx_cfg u_def (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx0), .o_Rx_DV(dv0), .o_Rx_Byte(byte0),
        .o_Parity_Err(perr0), .o_Frame_Err(ferr0), .o_Rx_Match(m0)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .MATCH_VALUE(8'h35)) u_par (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx1), .o_Rx_DV(dv1), .o_Rx_Byte(byte1),
        .o_Parity_Err(perr1), .o_Frame_Err(ferr1), .o_Rx_Match(m1)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(16), .STOP_BITS(2)) u_stop2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx2), .o_Rx_DV(dv2), .o_Rx_Byte(byte2),
        .o_Parity_Err(perr2), .o_Frame_Err(ferr2), .o_Rx_Match(m2)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(4)) u_fast (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx3), .o_Rx_DV(dv3), .o_Rx_Byte(byte3),
        .o_Parity_Err(perr3), .o_Frame_Err(ferr3), .o_Rx_Match(m3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) begin
            dv_cnt[i] = 0;
            m_cnt[i]  = 0;
            m_ok[i]   = 0;
        end
        prev_dv = '0;
    end

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        logic [3:0] v_dv;
        logic [3:0] v_m;
        v_dv = {dv3, dv2, dv1, dv0};
        v_m  = {m3, m2, m1, m0};
        for (int i = 0; i < 4; i++) begin
            if (v_m[i] === 1'b1) begin
                m_cnt[i]++;
                if (prev_dv[i] === 1'b1) m_ok[i]++;
            end
            if (v_dv[i] === 1'b1) begin
                if (i == 3) begin
                    if (dv_cnt[3] < 4) fast_byte[dv_cnt[3]] = byte3;
                    if (perr3 !== 1'b0 || ferr3 !== 1'b0) fast_err++;
                end
                dv_cnt[i]++;
            end
        end
        prev_dv = v_dv;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic b);
        case (sel)
            0: rx0 = b;
            1: rx1 = b;
            2: rx2 = b;
            default: rx3 = b;
        endcase
    endtask

    task automatic drive(input int sel, input logic b, input int n);
        set_line(sel, b);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input int cpb, input int nbits, input logic [8:0] data,
                              input bit par_en, input logic par_bit, input int nstop, input logic [1:0] stops);
        drive(sel, 1'b0, cpb);
        for (int i = 0; i < nbits; i++) drive(sel, data[i], cpb);
        if (par_en) drive(sel, par_bit, cpb);
        for (int i = 0; i < nstop; i++) drive(sel, stops[i], cpb);
    endtask

    initial begin
        logic [7:0] v_3c;
        v_3c = 8'h3C;
        rst = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1; rx3 = 1'b1;
        repeat (5) @(negedge clk);

        check("rst_dv",    {31'd0, dv0},   32'd0);
        check("rst_byte",  {24'd0, byte0}, 32'd0);
        check("rst_perr",  {31'd0, perr0}, 32'd0);
        check("rst_ferr",  {31'd0, ferr0}, 32'd0);
        check("rst_match", {31'd0, m0},    32'd0);

        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Default configuration, 0x41 at 87 clocks per bit.
        send_frame(0, 87, 8, 9'h041, 1'b0, 1'b0, 1, 2'b11);
        drive(0, 1'b1, 174);
        check("def_dv_cnt",   dv_cnt[0],      32'd1);
        check("def_byte",     {24'd0, byte0}, 32'h41);
        check("def_perr",     {31'd0, perr0}, 32'd0);
        check("def_ferr",     {31'd0, ferr0}, 32'd0);
        check("def_match",    m_cnt[0],       c_MEN);
        check("def_match_tm", m_ok[0],        c_MEN);

        // 30-clock low glitch is rejected at the start-bit midpoint.
        drive(0, 1'b0, 30);
        drive(0, 1'b1, 261);
        check("glitch_dv_cnt", dv_cnt[0],      32'd1);
        check("glitch_byte",   {24'd0, byte0}, 32'h41);
        check("glitch_ferr",   {31'd0, ferr0}, 32'd0);

        // Reset asserted during data bit 4 of 0x3C.
        drive(0, 1'b0, 87);
        for (int i = 0; i < 4; i++) drive(0, v_3c[i], 87);
        drive(0, 1'b1, 43);
        rst = 1'b1;
        drive(0, 1'b1, 3);
        rst = 1'b0;
        drive(0, 1'b1, 174);
        check("abort_dv_cnt", dv_cnt[0],      32'd1);
        check("abort_byte",   {24'd0, byte0}, 32'd0);
        check("abort_perr",   {31'd0, perr0}, 32'd0);
        check("abort_ferr",   {31'd0, ferr0}, 32'd0);
        check("abort_match",  {31'd0, m0},    32'd0);

        send_frame(0, 87, 8, 9'h0A5, 1'b0, 1'b0, 1, 2'b11);
        drive(0, 1'b1, 174);
        check("a5_dv_cnt", dv_cnt[0],      32'd2);
        check("a5_byte",   {24'd0, byte0}, 32'hA5);
        check("a5_ferr",   {31'd0, ferr0}, 32'd0);
        check("a5_match",  m_cnt[0],       c_MEN);

        // Even parity, 7 bits: 0x35 has four ones, so the correct parity bit is 0.
        send_frame(1, 16, 7, 9'h035, 1'b1, 1'b1, 1, 2'b01);
        drive(1, 1'b1, 48);
        check("par_dv_cnt", dv_cnt[1],      32'd1);
        check("par_byte",   {25'd0, byte1}, 32'h35);
        check("par_perr",   {31'd0, perr1}, 32'd1);
        check("par_ferr",   {31'd0, ferr1}, 32'd0);
        check("par_match",  m_cnt[1],       32'd0);

        send_frame(1, 16, 7, 9'h035, 1'b1, 1'b0, 1, 2'b01);
        drive(1, 1'b1, 48);
        check("parok_dv_cnt", dv_cnt[1],      32'd2);
        check("parok_perr",   {31'd0, perr1}, 32'd0);
        check("parok_match",  m_cnt[1],       c_MEN);
        check("parok_tm",     m_ok[1],        c_MEN);
        drive(1, 1'b1, 50);
        check("parok_hold",   {25'd0, byte1}, 32'h35);

        // Two stop bits, second one low.
        send_frame(2, 16, 8, 9'h05A, 1'b0, 1'b0, 2, 2'b01);
        drive(2, 1'b1, 48);
        check("stop2_dv_cnt", dv_cnt[2],      32'd1);
        check("stop2_byte",   {24'd0, byte2}, 32'h5A);
        check("stop2_ferr",   {31'd0, ferr2}, 32'd1);
        check("stop2_perr",   {31'd0, perr2}, 32'd0);

        // Break of 20 bit times produces exactly one frame.
        drive(2, 1'b0, 320);
        drive(2, 1'b1, 80);
        check("brk_dv_cnt", dv_cnt[2],      32'd2);
        check("brk_byte",   {24'd0, byte2}, 32'h00);
        check("brk_ferr",   {31'd0, ferr2}, 32'd1);

        // Back-to-back frames at 4 clocks per bit.
        send_frame(3, 4, 8, 9'h000, 1'b0, 1'b0, 1, 2'b01);
        send_frame(3, 4, 8, 9'h0FF, 1'b0, 1'b0, 1, 2'b01);
        send_frame(3, 4, 8, 9'h055, 1'b0, 1'b0, 1, 2'b01);
        drive(3, 1'b1, 20);
        check("fast_dv_cnt", dv_cnt[3],             32'd3);
        check("fast_b0",     {24'd0, fast_byte[0]}, 32'h00);
        check("fast_b1",     {24'd0, fast_byte[1]}, 32'hFF);
        check("fast_b2",     {24'd0, fast_byte[2]}, 32'h55);
        check("fast_err",    fast_err,              32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_cfg
`default_nettype wire

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 87, clocks per serial bit; legal range 4..65535.
REQ-002 SHALL provide parameter DATA_BITS, default 8, data bits per frame; legal 5..9.
REQ-003 SHALL provide parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL provide parameter STOP_BITS, default 1, stop bits checked; legal 1 or 2.
REQ-005 SHALL provide parameter MATCH_VALUE, default 8'h41, compare value for match feature, zero-extended to DATA_BITS.
REQ-006 SHALL have port i_Clock, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_Reset, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port i_Rx_Serial, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port o_Rx_DV, output, 1, one-cycle pulse when a frame completes.
REQ-010 SHALL have port o_Rx_Byte, output, DATA_BITS, received data, LSB first on the line.
REQ-011 SHALL have port o_Parity_Err, output, 1, parity mismatch, valid with o_Rx_DV.
REQ-012 SHALL have port o_Frame_Err, output, 1, any stop bit sampled low, valid with o_Rx_DV.
REQ-013 SHALL have port o_Rx_Match, output, 1, one-cycle pulse on a matching error-free frame.

Function
REQ-014 SHALL pass i_Rx_Serial through a two-flop synchroniser; all decisions use the synchronised line.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, CLEANUP.
REQ-016 IDLE: counter and bit index cleared; synchronised line low -> START.
REQ-017 START: count to (CLKS_PER_BIT-1)/2; line still low -> clear counter, enter DATA; line high -> IDLE, no pulse, no error flag.
REQ-018 DATA: sample every CLKS_PER_BIT clocks; bit k goes to o_Rx_Byte[k]; after bit DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
REQ-019 PARITY: sample one bit CLKS_PER_BIT clocks later; error if XOR of data and parity bit is 0 (odd) or 1 (even).
REQ-020 STOP: sample STOP_BITS bits at CLKS_PER_BIT spacing; any low sample sets frame error.
REQ-021 After the final stop sample SHALL assert o_Rx_DV for exactly one cycle, with o_Rx_Byte, o_Parity_Err and o_Frame_Err updated that cycle.
REQ-022 o_Rx_Byte and both error flags SHALL hold until the next o_Rx_DV.
REQ-023 Data SHALL be delivered even when an error flag is set.
REQ-024 CLEANUP: return to IDLE only when the synchronised line is high, so a break condition produces exactly one frame.
REQ-025 Counter width SHALL be $clog2(CLKS_PER_BIT) bits; the counter never wraps inside a bit period.
REQ-026 o_Parity_Err SHALL be constant 0 when PARITY=0.

Reset
REQ-027 i_Reset high SHALL force IDLE, clear counter, bit index, o_Rx_DV, o_Rx_Byte, both error flags and o_Rx_Match to 0, and set both synchroniser flops to 1.
REQ-028 Reset mid-frame SHALL abort the frame with no o_Rx_DV pulse; reception restarts on the next falling edge after release.

Configuration
REQ-029 Macro UART_RX_MATCH_EN defined: o_Rx_Match pulses one cycle, the cycle after o_Rx_DV, when o_Rx_Byte==MATCH_VALUE and neither error flag is set.
REQ-030 Macro UART_RX_MATCH_EN undefined: o_Rx_Match is present, tied 0, and no compare logic is built.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state encoding type and the parity-mode constants PAR_NONE, PAR_ODD and PAR_EVEN.
REQ-032 The synchroniser SHALL be sub-module uart_sync_2ff, a 1-bit, reset-to-1 two-flop synchroniser.

Verification
REQ-033 Defaults, frame 0x41 at 87 clk/bit -> one o_Rx_DV pulse, byte 0x41, no errors; with macro, o_Rx_Match pulses the next cycle.
REQ-034 PARITY=2, DATA_BITS=7, frame 0x35 with wrong parity bit -> o_Rx_DV with byte 0x35, o_Parity_Err=1, o_Rx_Match=0.
REQ-035 STOP_BITS=2, second stop bit driven low -> o_Frame_Err=1; a 20-bit-time break yields exactly one o_Rx_DV.
REQ-036 Low glitch of 30 clocks at 87 clk/bit -> no o_Rx_DV, FSM back in IDLE, flags unchanged.
REQ-037 i_Reset pulsed during data bit 4 -> no o_Rx_DV, all outputs 0; next frame 0xA5 is received correctly.
REQ-038 Back-to-back frames 0x00, 0xFF, 0x55 at 4 clk/bit -> three pulses with correct bytes and no errors.
